spin_readout: RTL
=================

# spin_readout

Synchronous readout stage directly downstream of the oscillator array. Samples N asynchronous oscillator outputs and a reference oscillator on the system clock, integrates per-oscillator phase mismatch against the reference over a programmable window, and resolves each oscillator to a binary spin. Provides the Ising solution vector and per-spin mismatch counts to the host/control logic.

## Interface
- N, 3, number of oscillators (spins) sampled
- CNT_W, 16, width of the window length and of the mismatch counters
- SETTLE, 4, clock cycles discarded after start to flush synchronizers (≥2)
- clk  in  1  system clock; all state on rising edge
- rstn  in  1  synchronous, active-low reset
- osc_in  in  N  raw oscillator outputs, asynchronous to clk
- ref_in  in  1  raw reference oscillator output, asynchronous to clk
- start  in  1  one-cycle request to begin a measurement; sampled only in IDLE
- window  in  CNT_W  measurement length in clk cycles; latched on accepted start
- count_sel  in  $clog2(N) (min 1)  selects the mismatch counter shown on count_out
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when spins/counts are updated
- spins  out  N  resolved spins; bit i = 1 means oscillator i anti-phase to reference
- count_out  out  CNT_W  mismatch count of oscillator count_sel from last measurement

## Operation
- Every osc_in bit and ref_in pass through a 2-flop synchronizer (free-running, also during reset).
- Per-cycle mismatch bit m[i] = osc_sync[i] XOR ref_sync.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
  - IDLE: start=1 → latch window into win_q, clear all counters and cycle counter → SETTLE. start in any other state ignored.
  - SETTLE: count SETTLE cycles, no accumulation → MEASURE; if win_q==0 go straight to DONE.
  - MEASURE: each cycle, cnt[i] += m[i] for all i; cycle counter increments; after exactly win_q accumulation cycles → DONE.
  - DONE: spins[i] = (2*cnt[i] > win_q), computed in CNT_W+1 bits (tie → 0); cnt copied to result registers; done=1 for this cycle; → IDLE.
- cnt[i] ≤ win_q, so no overflow; counters non-saturating by construction.
- count_out is combinational mux of result registers by count_sel; count_sel ≥ N returns 0.
- spins and result counts hold between measurements; only DONE updates them.

## Timing
- Reset (rstn=0 at clk edge): state IDLE, busy=0, done=0, spins=0, all counters and results 0, count_out=0; synchronizer flops cleared.
- Reset mid-measurement aborts; no done pulse; results return to 0.
- start accepted at edge k → busy=1 from k+1; SETTLE occupies k+1..k+SETTLE; MEASURE occupies the next window cycles; done high in cycle k+SETTLE+window+1; busy low from the cycle after done.
- window==0: done at k+SETTLE+1, spins=0, counts=0.
- start asserted in the DONE cycle ignored; start in the first IDLE cycle after DONE accepted (back-to-back measurements).
- Changes on window after acceptance have no effect until next start.
- Synchronizer latency: 2 cycles input to m[i]; covered by SETTLE ≥ 2.

## Structure
- Shared package ising_pkg: FSM state encoding (2-bit localparams IDLE/SETTLE/MEASURE/DONE), default CNT_W, default SETTLE.
- Sub-module sync_2ff (parameterized width, synchronous active-low reset); instantiated once with width N+1.
- Per-oscillator counter/compare in a generate loop inside spin_readout.

## Test plan
- Reset: rstn=0 for 3 cycles with toggling inputs → spins=0, busy=0, done=0, count_out=0.
- In-phase: osc_in=ref_in (same toggling source), window=100 → done at start+SETTLE+101, spins=3'b000, every count_out=0.
- Anti-phase bit 1: osc_in[1]=~ref_in, others equal, window=100 → spins=3'b010, count_out(sel=1)=100, sel=0 → 0.
- Tie and threshold: osc_in[0] mismatched exactly 50 of 100 cycles → spins[0]=0; 51 of 100 → spins[0]=1, count_out=51.
- window=0 and back-to-back: window=0 → done at start+SETTLE+1, spins=0; start in DONE cycle ignored, start next cycle accepted (busy=1 following cycle).
- Abort: rstn=0 during MEASURE after a prior result spins=3'b101 → no done, spins=0, next measurement runs normally.

Source files
------------

// File: rtl/ising_pkg.sv
// ising_pkg: FSM encoding and default sizes shared by the spin readout slice
package ising_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;
  localparam int CNT_W_DEF  = 16;
  localparam int SETTLE_DEF = 4;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer bank, cleared by synchronous active-low reset
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  always_ff @(posedge clk)
    if (!rstn) {q, s1} <= '0;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/spin_readout.sv
// spin_readout: integrates oscillator/reference phase mismatch over a window and resolves binary spins
module spin_readout
  import ising_pkg::*;
#(
  parameter  int N      = 3,
  parameter  int CNT_W  = CNT_W_DEF,
  parameter  int SETTLE = SETTLE_DEF,
  localparam int SW     = N > 1 ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     osc_in,
  input  logic             ref_in,
  input  logic             start,
  input  logic [CNT_W-1:0] window,
  input  logic [SW-1:0]    count_sel,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     spins,
  output logic [CNT_W-1:0] count_out
);
  logic [N:0]       s;
  logic [N-1:0]     m;
  state_t           state;
  logic [CNT_W-1:0] win_q, cyc;
  logic             accept, settle_end, to_done;
  logic [CNT_W-1:0] res [N];
  sync_2ff #(.W(N + 1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    ({ref_in, osc_in}),
    .q    (s)
  );
  assign m          = s[N-1:0] ^ {N{s[N]}};
  assign accept     = state == ST_IDLE && start;
  assign settle_end = state == ST_SETTLE && cyc == CNT_W'(SETTLE - 1);
  assign to_done    = (settle_end && win_q == '0) ||
                      (state == ST_MEASURE && cyc == win_q - CNT_W'(1));
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= ST_IDLE;
      win_q <= '0;
      cyc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= to_done;
      case (state)
        ST_IDLE:
          if (start) begin
            state <= ST_SETTLE;
            win_q <= window;
            cyc   <= '0;
            busy  <= 1'b1;
          end
        ST_SETTLE:
          if (settle_end) begin
            state <= win_q == '0 ? ST_DONE : ST_MEASURE;
            cyc   <= '0;
          end else cyc <= cyc + CNT_W'(1);
        ST_MEASURE:
          if (to_done) state <= ST_DONE;
          else cyc <= cyc + CNT_W'(1);
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  for (genvar i = 0; i < N; i++) begin : g_spin
    logic [CNT_W-1:0] c, nx, r;
    logic             sp;
    // nx includes the final accumulation so results land with the done pulse
    assign nx = c + CNT_W'(state == ST_MEASURE && m[i]);
    always_ff @(posedge clk)
      if (!rstn) begin
        c  <= '0;
        r  <= '0;
        sp <= 1'b0;
      end else begin
        c <= accept ? '0 : nx;
        if (to_done) begin
          r  <= nx;
          sp <= {nx, 1'b0} > {1'b0, win_q};
        end
      end
    assign res[i]   = r;
    assign spins[i] = sp;
  end
  always_comb begin
    count_out = '0;
    for (int j = 0; j < N; j++)
      if (count_sel == SW'(j)) count_out = res[j];
  end
endmodule
